// File: rtl/sim_check_pkg.sv
// Shared definitions for the simulation run checker: FSM state encoding and
// probe/index width constants used by the top and the probe comparator.
package sim_check_pkg;

  // Fixed state encoding so waveforms and bench messages read the same everywhere.
  localparam logic [1:0] ST_IDLE_ENC  = 2'd0;
  localparam logic [1:0] ST_RUN_ENC   = 2'd1;
  localparam logic [1:0] ST_CHECK_ENC = 2'd2;
  localparam logic [1:0] ST_DONE_ENC  = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = ST_IDLE_ENC,
    ST_RUN   = ST_RUN_ENC,
    ST_CHECK = ST_CHECK_ENC,
    ST_DONE  = ST_DONE_ENC
  } state_e;

  // Default width of one probe slice (and of pc).
  localparam int PROBE_SLICE_W = 32;

  // Width of the first-failing-channel index; covers up to 16 channels.
  localparam int FAIL_IDX_W = 4;

endpackage : sim_check_pkg

// File: rtl/sim_run_checker_probe_compare.sv
// probe_compare: combinational per-channel compare of probe words against
// expected values, gated by a channel mask, plus a lowest-index priority
// encoder for the first mismatching channel.
module probe_compare
  import sim_check_pkg::*;
#(
  parameter int DATA_W     = PROBE_SLICE_W,
  parameter int NUM_PROBES = 4
) (
  input  logic [NUM_PROBES*DATA_W-1:0] probe_data_i,
  input  logic [NUM_PROBES*DATA_W-1:0] probe_exp_i,
  input  logic [NUM_PROBES-1:0]        probe_mask_i,
  output logic [NUM_PROBES-1:0]        fail_mask_o,
  output logic [FAIL_IDX_W-1:0]        first_fail_o,
  output logic                         pass_o
);

  // Exact bitwise equality per channel; unchecked channels never fail.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first so no path leaves it unassigned (no latch).
    fail_mask_o = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      fail_mask_o[i] = probe_mask_i[i] &
                       (probe_data_i[i*DATA_W +: DATA_W] != probe_exp_i[i*DATA_W +: DATA_W]);
    end
  end

  // Scan from the top down so the lowest failing index is the one left standing.
  always_comb begin
    first_fail_o = '0;
    for (int i = NUM_PROBES - 1; i >= 0; i--) begin
      if (fail_mask_o[i]) begin
        first_fail_o = FAIL_IDX_W'(i);
      end
    end
  end

  // An all-zero mask checks nothing and therefore passes.
  assign pass_o = ~|fail_mask_o;

endmodule : probe_compare

// File: rtl/sim_run_checker.sv
// sim_run_checker: run monitor and self-checker for a core under simulation.
// Counts cycles from a start pulse, ends the run on a cycle limit (or on a pc
// halt when SIM_RUN_CHECKER_PC_HALT_EN is defined), then latches a pass/fail
// verdict over the masked probe channels.
// Optional feature macro: SIM_RUN_CHECKER_PC_HALT_EN (pc-halt detection).
module sim_run_checker
  import sim_check_pkg::*;
#(
  parameter int DATA_W      = PROBE_SLICE_W,
  parameter int NUM_PROBES  = 4,   // 1..16
  parameter int MAX_CYCLES  = 16,
  parameter int CNT_W       = 16,
  parameter int HALT_STABLE = 3    // >= 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic [DATA_W-1:0]            pc,
  input  logic [NUM_PROBES*DATA_W-1:0] probe_data,
  input  logic [NUM_PROBES*DATA_W-1:0] probe_exp,
  input  logic [NUM_PROBES-1:0]        probe_mask,
  output logic                         busy,
  output logic                         done,
  output logic                         pass,
  output logic [NUM_PROBES-1:0]        fail_mask,
  output logic [FAIL_IDX_W-1:0]        first_fail,
  output logic [CNT_W-1:0]             cycle_count,
  output logic                         halted
);

  state_e                  state_q;
  logic                    busy_q, done_q, pass_q, halted_q;
  logic [NUM_PROBES-1:0]   fail_mask_q;
  logic [FAIL_IDX_W-1:0]   first_fail_q;
  logic [CNT_W-1:0]        cycle_count_q;
  logic [CNT_W-1:0]        cycle_count_d;

  logic                    limit_hit;
  logic                    halt_hit;
  logic [NUM_PROBES-1:0]   cmp_fail_mask;
  logic [FAIL_IDX_W-1:0]   cmp_first_fail;
  logic                    cmp_pass;

  // Saturating increment: the counter sticks at all-ones instead of wrapping.
  assign cycle_count_d = (&cycle_count_q) ? cycle_count_q : cycle_count_q + CNT_W'(1);
  assign limit_hit     = (cycle_count_q == CNT_W'(MAX_CYCLES));

  probe_compare #(
    .DATA_W     (DATA_W),
    .NUM_PROBES (NUM_PROBES)
  ) u_probe_compare (
    .probe_data_i (probe_data),
    .probe_exp_i  (probe_exp),
    .probe_mask_i (probe_mask),
    .fail_mask_o  (cmp_fail_mask),
    .first_fail_o (cmp_first_fail),
    .pass_o       (cmp_pass)
  );

`ifdef SIM_RUN_CHECKER_PC_HALT_EN
  localparam int HOLD_W = $clog2(HALT_STABLE + 1);

  logic [DATA_W-1:0] pc_prev_q;
  logic [HOLD_W-1:0] hold_q;
  logic [HOLD_W-1:0] hold_d;

  // Number of consecutive run cycles pc has held its current value; the first
  // cycle of a run always counts as 1 because hold_q is cleared outside RUN.
  assign hold_d   = (pc == pc_prev_q) ? hold_q + HOLD_W'(1) : HOLD_W'(1);
  assign halt_hit = (state_q == ST_RUN) && (hold_d == HOLD_W'(HALT_STABLE));

  // pc history: previous pc every cycle, hold length only while running.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_prev_q <= '0;
      hold_q    <= '0;
    end else begin
      pc_prev_q <= pc;
      hold_q    <= (state_q == ST_RUN) ? hold_d : '0;
    end
  end
`else
  logic unused_pc;

  // Without halt detection pc has no effect on the run.
  assign unused_pc = ^pc;
  assign halt_hit  = 1'b0;
`endif

  // Run FSM with registered status, counter and verdict outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      state_q       <= ST_IDLE;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
      fail_mask_q   <= '0;
      first_fail_q  <= '0;
      cycle_count_q <= '0;
      halted_q      <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state_q       <= ST_RUN;
            busy_q        <= 1'b1;
            done_q        <= 1'b0;
            pass_q        <= 1'b0;
            fail_mask_q   <= '0;
            first_fail_q  <= '0;
            halted_q      <= 1'b0;
            cycle_count_q <= CNT_W'(1);
          end
        end
        ST_RUN: begin
          if (limit_hit || halt_hit) begin
            state_q  <= ST_CHECK;
            halted_q <= halt_hit;
          end else begin
            cycle_count_q <= cycle_count_d;
          end
        end
        ST_CHECK: begin
          state_q      <= ST_DONE;
          busy_q       <= 1'b0;
          done_q       <= 1'b1;
          pass_q       <= cmp_pass;
          fail_mask_q  <= cmp_fail_mask;
          first_fail_q <= cmp_first_fail;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign pass        = pass_q;
  assign fail_mask   = fail_mask_q;
  assign first_fail  = first_fail_q;
  assign cycle_count = cycle_count_q;
  assign halted      = halted_q;

endmodule : sim_run_checker

// File: tb/tb_sim_run_checker.sv
// Self-checking bench for sim_run_checker: directed verdict table, multi-cycle
// corner sequences (start ignored in RUN/CHECK, reset mid-run and in DONE,
// pc halt), and randomized runs against a behavioural reference model.
// Works with or without SIM_RUN_CHECKER_PC_HALT_EN defined.
module tb_sim_run_checker;

  localparam int DATA_W      = 32;
  localparam int NUM_PROBES  = 4;
  localparam int MAX_CYCLES  = 16;
  localparam int CNT_W       = 16;
  localparam int HALT_STABLE = 3;
  localparam int PW          = NUM_PROBES * DATA_W;

`ifdef SIM_RUN_CHECKER_PC_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  logic                  clk = 1'b0;
  logic                  reset;
  logic                  start;
  logic [DATA_W-1:0]     pc;
  logic [PW-1:0]         probe_data;
  logic [PW-1:0]         probe_exp;
  logic [NUM_PROBES-1:0] probe_mask;
  logic                  busy, done, pass, halted;
  logic [NUM_PROBES-1:0] fail_mask;
  logic [3:0]            first_fail;
  logic [CNT_W-1:0]      cycle_count;

  int n_tests = 0;
  int n_fail  = 0;

  // pc value presented in run cycle k (index 0 = the start cycle).
  logic [31:0] pc_tr [64];

  typedef struct {
    string     name;
    logic [PW-1:0] data;
    logic [PW-1:0] expv;
    logic [3:0]    mask;
    logic          exp_pass;
    logic [3:0]    exp_fm;
    logic [3:0]    exp_ff;
  } vec_t;

  vec_t vecs [7];

  always #5 clk = ~clk;

  sim_run_checker #(
    .DATA_W      (DATA_W),
    .NUM_PROBES  (NUM_PROBES),
    .MAX_CYCLES  (MAX_CYCLES),
    .CNT_W       (CNT_W),
    .HALT_STABLE (HALT_STABLE)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .pc          (pc),
    .probe_data  (probe_data),
    .probe_exp   (probe_exp),
    .probe_mask  (probe_mask),
    .busy        (busy),
    .done        (done),
    .pass        (pass),
    .fail_mask   (fail_mask),
    .first_fail  (first_fail),
    .cycle_count (cycle_count),
    .halted      (halted)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [PW-1:0] pk(input logic [31:0] c0, c1, c2, c3);
    return {c3, c2, c1, c0};
  endfunction

  function automatic logic [PW-1:0] rand_words();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic void set_pc_linear();
    for (int k = 0; k < 64; k++) pc_tr[k] = 32'(4 * k);
  endfunction

  // Reference: the run ends at the first cycle that reaches the limit or that
  // completes HALT_STABLE cycles of an unchanged pc inside the run.
  function automatic void model_run(output int cnt, output bit hlt);
    int run_len = 0;
    cnt = MAX_CYCLES;
    hlt = 1'b0;
    for (int k = 1; k <= MAX_CYCLES; k++) begin
      run_len = (k > 1 && pc_tr[k] == pc_tr[k-1]) ? run_len + 1 : 1;
      if (HALT_EN && run_len >= HALT_STABLE) begin
        cnt = k;
        hlt = 1'b1;
        return;
      end
    end
  endfunction

  // Reference verdict: masked channels must match exactly.
  function automatic void model_verdict(input logic [PW-1:0] d, input logic [PW-1:0] e,
                                        input logic [3:0] m, output logic p,
                                        output logic [3:0] fm, output logic [3:0] ff);
    int nfail = 0;
    fm = '0;
    ff = '0;
    for (int i = 0; i < NUM_PROBES; i++) begin
      if (m[i] && (d[i*DATA_W +: DATA_W] != e[i*DATA_W +: DATA_W])) begin
        fm[i] = 1'b1;
        if (nfail == 0) ff = 4'(i);
        nfail++;
      end
    end
    p = (nfail == 0);
  endfunction

  // One complete run from IDLE/DONE: start, wait for done, check verdict,
  // latency and that results stay frozen. With scramble set, probe_data is
  // random in every cycle except the CHECK cycle.
  task automatic run_and_check(input string tag, input logic [PW-1:0] d, input logic [PW-1:0] e,
                               input logic [3:0] m, input logic exp_pass, input logic [3:0] exp_fm,
                               input logic [3:0] exp_ff, input int exp_cnt, input logic exp_halt,
                               input bit scramble);
    int lat = -1;
    pc         = pc_tr[0];
    probe_data = d;
    probe_exp  = e;
    probe_mask = m;
    start = 1'b1;
    tick();
    start = 1'b0;
    check({tag, ".start_state"},
          {busy, done, pass, fail_mask, first_fail, halted, cycle_count},
          {1'b1, 1'b0, 1'b0, 4'h0, 4'h0, 1'b0, 16'd1});
    for (int k = 1; k <= 200 && lat < 0; k++) begin
      pc         = pc_tr[(k < 64) ? k : 63];
      probe_data = (scramble && k != exp_cnt + 1) ? rand_words() : d;
      tick();
      if (done) lat = k;
    end
    check({tag, ".latency"}, lat, exp_cnt + 1);
    check({tag, ".pass"}, pass, exp_pass);
    check({tag, ".fail_mask"}, fail_mask, exp_fm);
    check({tag, ".first_fail"}, first_fail, exp_ff);
    check({tag, ".cycle_count"}, cycle_count, exp_cnt);
    check({tag, ".halted"}, halted, exp_halt);
    check({tag, ".busy"}, busy, 1'b0);
    repeat (2) begin
      probe_data = rand_words();
      pc         = $urandom;
      tick();
    end
    check({tag, ".frozen"},
          {done, pass, fail_mask, first_fail, halted, cycle_count},
          {1'b1, exp_pass, exp_fm, exp_ff, exp_halt, 16'(exp_cnt)});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [PW-1:0] match_d;
    logic [PW-1:0] rd, re;
    logic [3:0]    rm, efm, eff;
    logic          ep;
    int            ecnt;
    bit            ehlt;

    reset      = 1'b1;
    start      = 1'b0;
    pc         = '0;
    probe_data = '0;
    probe_exp  = '0;
    probe_mask = '0;
    repeat (2) tick();
    reset = 1'b0;

    check("reset.busy", busy, 1'b0);
    check("reset.done", done, 1'b0);
    check("reset.pass", pass, 1'b0);
    check("reset.fail_mask", fail_mask, 4'h0);
    check("reset.first_fail", first_fail, 4'h0);
    check("reset.cycle_count", cycle_count, 16'd0);
    check("reset.halted", halted, 1'b0);
    tick();
    check("idle.no_start", {busy, done, cycle_count}, 18'd0);

    // Channels: 0 = t7, 1 = mem[8], 2 = write data, 3 = address.
    match_d = pk(32'd60, 32'd60, 32'd60, 32'd8);
    vecs[0] = '{"match",     match_d, match_d,                                          4'hF, 1'b1, 4'b0000, 4'd0};
    vecs[1] = '{"ch2_61",    match_d, pk(32'd60, 32'd60, 32'd61, 32'd8),                4'hF, 1'b0, 4'b0100, 4'd2};
    vecs[2] = '{"mask0",     pk(32'd1, 32'd2, 32'd3, 32'd4), pk(32'd5, 32'd6, 32'd7, 32'd9), 4'h0, 1'b1, 4'b0000, 4'd0};
    vecs[3] = '{"ch1_ch3",   match_d, pk(32'd60, 32'd59, 32'd60, 32'd9),                4'hF, 1'b0, 4'b1010, 4'd1};
    vecs[4] = '{"ch3_masked",match_d, pk(32'd60, 32'd59, 32'd60, 32'd9),                4'h7, 1'b0, 4'b0010, 4'd1};
    vecs[5] = '{"only_ch3",  pk(32'd1, 32'd2, 32'd3, 32'd8), pk(32'd9, 32'd9, 32'd9, 32'd12), 4'h8, 1'b0, 4'b1000, 4'd3};
    vecs[6] = '{"no_sext",   pk(32'hFFFF_FFFF, 32'd60, 32'd60, 32'd8), pk(32'h0000_FFFF, 32'd60, 32'd60, 32'd8),
                4'hF, 1'b0, 4'b0001, 4'd0};

    set_pc_linear();
    for (int v = 0; v < 7; v++) begin
      run_and_check(vecs[v].name, vecs[v].data, vecs[v].expv, vecs[v].mask, vecs[v].exp_pass,
                    vecs[v].exp_fm, vecs[v].exp_ff, MAX_CYCLES, 1'b0, 1'b0);
    end

    // start pulse during CHECK is ignored; the run still completes normally.
    probe_data = match_d;
    probe_exp  = match_d;
    probe_mask = 4'hF;
    pc         = 32'h100;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) begin
      pc = pc + 32'd4;
      tick();
    end
    check("check_start.in_run", {busy, done, cycle_count}, {1'b1, 1'b0, 16'd16});
    pc = pc + 32'd4;
    tick();
    check("check_start.in_check", {busy, done, cycle_count}, {1'b1, 1'b0, 16'd16});
    start = 1'b1;
    pc = pc + 32'd4;
    tick();
    start = 1'b0;
    check("check_start.done", {busy, done, pass, cycle_count}, {1'b0, 1'b1, 1'b1, 16'd16});

    // start pulse during RUN is ignored; reset at cycle 8 aborts the run.
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (4) begin
      pc = pc + 32'd4;
      tick();
    end
    check("run_start.before", cycle_count, 16'd5);
    start = 1'b1;
    pc = pc + 32'd4;
    tick();
    start = 1'b0;
    check("run_start.ignored", {busy, cycle_count}, {1'b1, 16'd6});
    repeat (2) begin
      pc = pc + 32'd4;
      tick();
    end
    check("run_reset.cycle8", cycle_count, 16'd8);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("run_reset.after", {busy, done, pass, halted, cycle_count}, 20'd0);
    repeat (2) tick();
    check("run_reset.idle", {busy, done, cycle_count}, 18'd0);

    // pc frozen at 240 from cycle 5: halt after three unchanged cycles when enabled.
    for (int k = 0; k < 64; k++) pc_tr[k] = (k < 5) ? 32'(4 * k) : 32'd240;
    run_and_check("halt", match_d, match_d, 4'hF, 1'b1, 4'h0, 4'h0,
                  HALT_EN ? 7 : MAX_CYCLES, HALT_EN, 1'b0);

    // Randomized runs against the reference model.
    for (int r = 0; r < 30; r++) begin
      pc_tr[0] = $urandom;
      for (int k = 1; k < 64; k++) pc_tr[k] = ($urandom_range(0, 1) == 0) ? pc_tr[k-1] : $urandom;
      rd = rand_words();
      re = rd;
      for (int i = 0; i < NUM_PROBES; i++) begin
        if ($urandom_range(0, 1) == 0) re[i*DATA_W + int'($urandom_range(0, DATA_W - 1))] ^= 1'b1;
      end
      rm = 4'($urandom_range(0, 15));
      model_run(ecnt, ehlt);
      model_verdict(rd, re, rm, ep, efm, eff);
      run_and_check($sformatf("rand%0d", r), rd, re, rm, ep, efm, eff, ecnt, ehlt, 1'b1);
    end

    // Reset in DONE drops the verdict.
    set_pc_linear();
    run_and_check("pre_reset", vecs[3].data, vecs[3].expv, vecs[3].mask, vecs[3].exp_pass,
                  vecs[3].exp_fm, vecs[3].exp_ff, MAX_CYCLES, 1'b0, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("done_reset", {busy, done, pass, fail_mask, first_fail, halted, cycle_count}, 28'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_sim_run_checker
